// File: rtl/dpram_port_arbiter.sv
`default_nettype none
// ============================================================================
// dpram_port_arbiter
// Clears a dual-port RAM after reset, then arbitrates two clients onto it.
// Revision: 1.0
// ============================================================================
module dpram_port_arbiter #(
    parameter int              AW       = 4,
    parameter int              DW       = 8,
    parameter logic [DW-1:0]   INIT_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               a_req_valid,
    output logic               a_req_ready,
    input  logic               a_req_we,
    input  logic [AW-1:0]      a_req_addr,
    input  logic [DW-1:0]      a_req_wdata,
    output logic               a_rsp_valid,
    output logic [DW-1:0]      a_rsp_rdata,

    input  logic               b_req_valid,
    output logic               b_req_ready,
    input  logic               b_req_we,
    input  logic [AW-1:0]      b_req_addr,
    input  logic [DW-1:0]      b_req_wdata,
    output logic               b_rsp_valid,
    output logic [DW-1:0]      b_rsp_rdata,

    output logic [AW-1:0]      ram_addr_a,
    output logic [DW-1:0]      ram_din_a,
    output logic               ram_we_a,
    output logic [AW-1:0]      ram_addr_b,
    output logic [DW-1:0]      ram_din_b,
    output logic               ram_we_b,
    input  logic [DW-1:0]      ram_dout_a,
    input  logic [DW-1:0]      ram_dout_b,

    output logic               init_done,
    output logic [15:0]        collision_cnt
);

    localparam int              IW        = AW - 1;
    localparam logic [IW-1:0]   INIT_LAST = '1;
    localparam logic [0:0]      ST_INIT   = 1'b0;
    localparam logic [0:0]      ST_RUN    = 1'b1;

    logic [0:0]     state_q,     state_d;
    logic [IW-1:0]  init_cnt_q,  init_cnt_d;
    logic           prio_b_q,    prio_b_d;
    logic [15:0]    coll_q,      coll_d;
    logic           a_rsp_q,     a_rsp_d;
    logic           a_rd_q,      a_rd_d;
    logic           b_rsp_q,     b_rsp_d;
    logic           b_rd_q,      b_rd_d;

    logic           w_run;
    logic           w_conflict;
    logic           w_a_acc;
    logic           w_b_acc;

    assign w_run      = (state_q == ST_RUN) && !rst;
    assign w_conflict = a_req_valid && b_req_valid && (a_req_addr == b_req_addr)
                        && (a_req_we || b_req_we);
    assign w_a_acc    = a_req_valid && a_req_ready;
    assign w_b_acc    = b_req_valid && b_req_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            prio_b_q   <= 1'b0;
            coll_q     <= '0;
            a_rsp_q    <= 1'b0;
            a_rd_q     <= 1'b0;
            b_rsp_q    <= 1'b0;
            b_rd_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            prio_b_q   <= prio_b_d;
            coll_q     <= coll_d;
            a_rsp_q    <= a_rsp_d;
            a_rd_q     <= a_rd_d;
            b_rsp_q    <= b_rsp_d;
            b_rd_q     <= b_rd_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prio_b_d   = prio_b_q;
        coll_d     = coll_q;
        a_rsp_d    = w_a_acc;
        a_rd_d     = w_a_acc && !a_req_we;
        b_rsp_d    = w_b_acc;
        b_rd_d     = w_b_acc && !b_req_we;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == INIT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // The loser of a conflict owns priority for the next one
                if (w_conflict) begin
                    prio_b_d = !prio_b_q;
                    if (coll_q != 16'hFFFF) begin
                        coll_d = coll_q + 16'd1;
                    end
                end
            end
        endcase
    end

    // Output logic
    always_comb begin
        a_req_ready = w_run && (!w_conflict || !prio_b_q);
        b_req_ready = w_run && (!w_conflict ||  prio_b_q);
        ram_addr_a  = '0;
        ram_din_a   = '0;
        ram_we_a    = 1'b0;
        ram_addr_b  = '0;
        ram_din_b   = '0;
        ram_we_b    = 1'b0;
        if (!rst) begin
            if (state_q == ST_INIT) begin
                ram_addr_a = {init_cnt_q, 1'b0};
                ram_addr_b = {init_cnt_q, 1'b1};
                ram_din_a  = INIT_VAL;
                ram_din_b  = INIT_VAL;
                ram_we_a   = 1'b1;
                ram_we_b   = 1'b1;
            end else begin
                ram_addr_a = a_req_addr;
                ram_din_a  = a_req_wdata;
                ram_we_a   = w_a_acc && a_req_we;
                ram_addr_b = b_req_addr;
                ram_din_b  = b_req_wdata;
                ram_we_b   = w_b_acc && b_req_we;
            end
        end
    end

    assign a_rsp_valid   = a_rsp_q;
    assign b_rsp_valid   = b_rsp_q;
    assign a_rsp_rdata   = a_rd_q ? ram_dout_a : '0;
    assign b_rsp_rdata   = b_rd_q ? ram_dout_b : '0;
    assign init_done     = (state_q == ST_RUN);
    assign collision_cnt = coll_q;

endmodule
`default_nettype wire

// File: tb/tb_dpram_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dpram_port_arbiter
// Directed bench with a behavioural RAM, reference memory and response queues.
// Revision: 1.0
// ============================================================================
module tb_dpram_port_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req_valid = 1'b0, a_req_we = 1'b0;
    logic [AW-1:0] a_req_addr = '0;
    logic [DW-1:0] a_req_wdata = '0;
    logic          b_req_valid = 1'b0, b_req_we = 1'b0;
    logic [AW-1:0] b_req_addr = '0;
    logic [DW-1:0] b_req_wdata = '0;
    logic          a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
    logic [DW-1:0] a_rsp_rdata, b_rsp_rdata;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
    logic          ram_we_a, ram_we_b, init_done;
    logic [15:0]   collision_cnt;

    int            n_total = 0;
    int            n_pass  = 0;
    logic [DW-1:0] ram   [2**AW];
    logic [DW-1:0] model [2**AW];
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic          pend_a = 1'b0, pend_b = 1'b0;

    always #5 clk = ~clk;

    dpram_port_arbiter #(.AW(AW), .DW(DW), .INIT_VAL(8'h00)) dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
        .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a), .ram_we_a(ram_we_a),
        .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b), .ram_we_b(ram_we_b),
        .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b),
        .init_done(init_done), .collision_cnt(collision_cnt)
    );

    // Behavioural dual_port_ram with registered read
    always @(posedge clk) begin
        if (ram_we_a) ram[ram_addr_a] <= ram_din_a;
        if (ram_we_b) ram[ram_addr_b] <= ram_din_b;
        ram_dout_a <= ram[ram_addr_a];
        ram_dout_b <= ram[ram_addr_b];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Response scoreboard: compare last cycle's accepts, then record this cycle's
    always @(negedge clk) begin
        if (pend_a || a_rsp_valid) begin
            check("a_rsp_valid", a_rsp_valid, pend_a);
            if (pend_a) check("a_rsp_rdata", a_rsp_rdata, qa.pop_front());
        end
        if (pend_b || b_rsp_valid) begin
            check("b_rsp_valid", b_rsp_valid, pend_b);
            if (pend_b) check("b_rsp_rdata", b_rsp_rdata, qb.pop_front());
        end
        pend_a = 1'b0;
        pend_b = 1'b0;
        if (!rst && a_req_valid && a_req_ready) begin
            pend_a = 1'b1;
            if (a_req_we) begin
                model[a_req_addr] = a_req_wdata;
                qa.push_back('0);
            end else begin
                qa.push_back(model[a_req_addr]);
            end
        end
        if (!rst && b_req_valid && b_req_ready) begin
            pend_b = 1'b1;
            if (b_req_we) begin
                model[b_req_addr] = b_req_wdata;
                qb.push_back('0);
            end else begin
                qb.push_back(model[b_req_addr]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a_req_valid = v; a_req_we = we; a_req_addr = ad; a_req_wdata = d;
    endtask

    task automatic drive_b(input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        b_req_valid = v; b_req_we = we; b_req_addr = ad; b_req_wdata = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2**AW; i++) model[i] = 8'h00;
        step();
        @(negedge clk);
        check("rst_init_done", init_done, 0);
        check("rst_collision_cnt", collision_cnt, 0);
        check("rst_ram_we", {ram_we_a, ram_we_b}, 0);
        check("rst_rsp_valid", {a_rsp_valid, b_rsp_valid}, 0);
        check("rst_ready", {a_req_ready, b_req_ready}, 0);
        step();
        rst = 1'b0;
    endtask

    task automatic run_init();
        for (int k = 0; k < 2**(AW-1); k++) begin
            @(negedge clk);
            check("init_we", {ram_we_a, ram_we_b}, 2'b11);
            check("init_addr_a", ram_addr_a, 2*k);
            check("init_addr_b", ram_addr_b, 2*k+1);
            check("init_din", {ram_din_a, ram_din_b}, 0);
            check("init_ready", {a_req_ready, b_req_ready}, 0);
            check("init_done_low", init_done, 0);
            step();
        end
        @(negedge clk);
        check("init_done_high", init_done, 1);
    endtask

    initial begin
        // Reset, initialisation, with an A read of address 5 held pending throughout
        do_reset();
        drive_a(1, 0, 5, 8'h00);
        run_init();
        check("ready_after_init", a_req_ready, 1);
        check("we_after_init", {ram_we_a, ram_we_b}, 0);
        step();
        drive_a(0, 0, 0, 0);
        step();

        // A writes 1 = AA then reads it back
        drive_a(1, 1, 1, 8'hAA);
        @(negedge clk); check("a_wr_ready", a_req_ready, 1);
        step();
        drive_a(1, 0, 1, 8'h00);
        step();
        drive_a(0, 0, 0, 0);
        step();
        check("coll_zero", collision_cnt, 0);

        // B writes 2 while A reads 1: no conflict
        drive_b(1, 1, 2, 8'h55);
        drive_a(1, 0, 1, 8'h00);
        @(negedge clk); check("both_ready", {a_req_ready, b_req_ready}, 2'b11);
        step();
        drive_a(0, 0, 0, 0);
        drive_b(1, 0, 2, 8'h00);
        step();
        drive_b(0, 0, 0, 0);
        step();

        // Write-write conflict on 3: A has priority, B stalls one cycle
        drive_a(1, 1, 3, 8'hF0);
        drive_b(1, 1, 3, 8'h0F);
        @(negedge clk); check("conf1_ready", {a_req_ready, b_req_ready}, 2'b10);
        step();
        drive_a(0, 0, 0, 0);
        @(negedge clk); check("conf1_b_retry", b_req_ready, 1);
        step();
        drive_b(0, 0, 0, 0);
        drive_a(1, 0, 3, 8'h00);
        @(negedge clk); check("coll_one", collision_cnt, 1);
        step();
        drive_a(0, 0, 0, 0);
        step();

        // Repeat of the conflict: B now holds priority
        drive_a(1, 1, 3, 8'h11);
        drive_b(1, 1, 3, 8'h22);
        @(negedge clk); check("conf2_ready", {a_req_ready, b_req_ready}, 2'b01);
        step();
        drive_b(0, 0, 0, 0);
        @(negedge clk); check("conf2_a_retry", a_req_ready, 1);
        step();
        drive_a(0, 0, 0, 0);
        drive_b(1, 0, 3, 8'h00);
        @(negedge clk); check("coll_two", collision_cnt, 2);
        step();
        drive_b(0, 0, 0, 0);
        step();

        // Read-read of the same address is not a conflict
        drive_a(1, 0, 1, 8'h00);
        drive_b(1, 0, 1, 8'h00);
        @(negedge clk); check("rr_ready", {a_req_ready, b_req_ready}, 2'b11);
        step();
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        step();
        check("coll_still_two", collision_cnt, 2);

        // Reset in the 4th INIT cycle restarts the sequence from (0,1)
        do_reset();
        for (int k = 0; k < 3; k++) step();
        rst = 1'b1;
        @(negedge clk); check("rst_forces_we", {ram_we_a, ram_we_b}, 0);
        step();
        rst = 1'b0;
        run_init();
        check("coll_cleared", collision_cnt, 0);
        step();

        // Priority returns to A after reset; the cleared RAM reads back zero
        drive_a(1, 1, 0, 8'h33);
        drive_b(1, 1, 0, 8'h44);
        @(negedge clk); check("prio_reset", {a_req_ready, b_req_ready}, 2'b10);
        step();
        drive_a(1, 0, 3, 8'h00);
        step();
        drive_a(0, 0, 0, 0);
        drive_b(1, 0, 0, 8'h00);
        step();
        drive_b(0, 0, 0, 0);
        step();
        step();
        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Collision-avoiding initiator that sits in front of `dual_port_ram` and owns both of its ports. Two independent clients (A, B) issue valid/ready read/write requests. The block forwards them to the RAM, serialises same-address conflicts with rotating priority, and returns read data one cycle later. After every reset it first clears the whole RAM to a known value, so downstream logic never reads uninitialised contents.

## Interface
Parameters:
- `AW`, 4, RAM address width (depth 2^AW, must be even).
- `DW`, 8, data width.
- `INIT_VAL`, 0, word written to every RAM location during initialisation.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `a_req_valid` / `b_req_valid`  in  1  client request present.
- `a_req_ready` / `b_req_ready`  out  1  request accepted this cycle (valid & ready).
- `a_req_we` / `b_req_we`  in  1  1 = write, 0 = read.
- `a_req_addr` / `b_req_addr`  in  AW  request address.
- `a_req_wdata` / `b_req_wdata`  in  DW  write data.
- `a_rsp_valid` / `b_rsp_valid`  out  1  one-cycle completion strobe, for reads and writes.
- `a_rsp_rdata` / `b_rsp_rdata`  out  DW  read data; 0 for writes.
- `ram_addr_a`, `ram_din_a`, `ram_we_a`  out  AW/DW/1  to RAM port A.
- `ram_addr_b`, `ram_din_b`, `ram_we_b`  out  AW/DW/1  to RAM port B.
- `ram_dout_a` / `ram_dout_b`  in  DW  RAM read data, registered, valid one cycle after the address.
- `init_done`  out  1  high once initialisation is complete.
- `collision_cnt`  out  16  count of arbitrated conflicts, saturating.

## Operation
- States: INIT, RUN.
- `rst` forces INIT, clears the init counter, sets priority to A, clears `collision_cnt`, and clears `init_done`.
- INIT:
  - Lasts 2^(AW-1) cycles, with cycle index k = 0..2^(AW-1)-1.
  - Port A writes address 2k and port B writes address 2k+1, both with `INIT_VAL`.
  - Both `*_req_ready` = 0 throughout.
  - After the last write, transition to RUN.
- RUN:
  - RAM port X is driven combinationally from client X's request when that request is accepted; otherwise `ram_we_X` = 0.
  - Conflict = `a_req_valid & b_req_valid & (a_req_addr == b_req_addr) & (a_req_we | b_req_we)`.
  - No conflict: both ready = 1.
  - Conflict: the priority holder's ready = 1 and the other's ready = 0. Priority then toggles to the loser, and `collision_cnt` increments, saturating at 0xFFFF.
  - Read-read to the same address is not a conflict.
  - The loser must hold its request stable; it wins the next cycle unless a new conflict arises, and priority guarantees it wins the next conflict.
- Responses:
  - An accepted request on X yields `X_rsp_valid` = 1 exactly one cycle later.
  - `X_rsp_rdata` = `ram_dout_X` for reads, 0 for writes.
  - Responses have no backpressure.
- Ready may depend combinationally on the valid, address and we inputs.

## Timing
- While `rst` = 1 at an edge, every output is 0 in the following cycle. RAM outputs are forced to 0 combinationally while `rst` is high.
- INIT begins in the first cycle after `rst` falls. For AW = 4, `ram_we_a/b` are high for exactly 8 cycles.
- `init_done` rises in the cycle after the final init write. The earliest request acceptance is that same cycle.
- Read latency is 1 cycle, from the accept edge to `rsp_valid` with data.
- Write data is visible to a read accepted in the following cycle.
- Reset asserted mid-INIT or mid-RUN:
  - Pending responses are discarded.
  - INIT restarts at address 0.
- Asserting `valid` during INIT has no effect; the request stays pending until RUN.

## Test plan
- Reset 2 cycles, release → 8 cycles of `ram_we_a/b` = 1 with address pairs (0,1)..(14,15) and din 0x00; `init_done` = 1 in the 9th cycle; A read of address 5 → `a_rsp_rdata` = 0x00 one cycle later.
- A writes address 1 = 0xAA, then A reads address 1 → `a_rsp_valid` with 0xAA one cycle after the read accept; `collision_cnt` = 0.
- Same cycle: B writes address 2 = 0x55 and A reads address 1 → both ready; A gets 0xAA; a later B read of address 2 → 0x55.
- Same cycle: A writes address 3 = 0xF0 and B writes address 3 = 0x0F → A accepted and B stalled 1 cycle, then B accepted; a read of address 3 → 0x0F; `collision_cnt` = 1. A repeat of the conflict → B wins; `collision_cnt` = 2.
- A and B both read address 1 in the same cycle → both accepted, both return 0xAA; `collision_cnt` unchanged.
- Assert `rst` in the 4th INIT cycle → the INIT sequence restarts at addresses (0,1), with 8 full write cycles before `init_done`.
